// File: rtl/decoder_pkg.sv
// Shared types and default constants for the registered 3-to-8 decoder.
// Imported by decoder_3to8_seq and hold_timer.
package decoder_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } dec_state_t;

  localparam int DEC_N           = 3;
  localparam int DEC_HOLD_CYCLES = 4;

endpackage : decoder_pkg

// File: rtl/hold_timer.sv
// Loadable saturating down-counter with a zero flag; times the one-hot hold window.
// Load value is HOLD_CYCLES-1 so that the zero flag rises on the last held cycle.
module hold_timer
  import decoder_pkg::*;
#(
  parameter int HOLD_CYCLES = DEC_HOLD_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic clear,
  input  logic dec,
  output logic zero
);

  localparam int CW = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] LOAD_VALUE = CW'(HOLD_CYCLES - 1);

  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;

  always_comb begin
    count_next = count_reg;
    if (clear) begin
      count_next = '0;
    end else if (load) begin
      count_next = LOAD_VALUE;
    end else if (dec && (count_reg != '0)) begin
      // Saturate at zero rather than wrapping.
      count_next = count_reg - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign zero = (count_reg == '0);

endmodule : hold_timer

// File: rtl/decoder_3to8_seq.sv
// Registered N-to-2**N decoder: each accepted code drives one output line for a hold window.
// Define DEC_ACK_EN to end the window on a sink ack instead of the hold_timer count.
module decoder_3to8_seq
  import decoder_pkg::*;
#(
  parameter int N           = DEC_N,
  parameter int HOLD_CYCLES = DEC_HOLD_CYCLES
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            valid,
  input  logic [N-1:0]    code,
  output logic            ready,
  output logic [2**N-1:0] y,
  output logic            done
`ifdef DEC_ACK_EN
  ,
  input  logic            ack
`endif
);

  localparam int W = 2**N;

  dec_state_t   state_reg;
  dec_state_t   state_next;
  logic [W-1:0] y_reg;
  logic [W-1:0] y_next;
  logic         done_reg;
  logic         done_next;
  logic [W-1:0] decoded;
  logic         accept;
  logic         hold_end;

  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_decode
      assign decoded[gi] = (code == N'(gi));
    end
  endgenerate

  // Held low while reset is asserted so nothing is offered before the block is live.
  assign ready  = rst_n & en & (state_reg == IDLE);
  assign accept = valid & ready;

`ifdef DEC_ACK_EN
  assign hold_end = ack;

  always_comb begin
    state_next = state_reg;
    y_next     = y_reg;
    done_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        y_next = '0;
        if (accept) begin
          y_next     = decoded;
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (!en) begin
          y_next     = '0;
          state_next = IDLE;
        end else if (hold_end) begin
          y_next     = '0;
          done_next  = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        y_next     = '0;
        state_next = IDLE;
      end
    endcase
  end
`else
  logic timer_load;
  logic timer_clear;
  logic timer_dec;
  logic timer_zero;

  hold_timer #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_hold_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .load (timer_load),
    .clear(timer_clear),
    .dec  (timer_dec),
    .zero (timer_zero)
  );

  assign hold_end = timer_zero;

  always_comb begin
    state_next  = state_reg;
    y_next      = y_reg;
    done_next   = 1'b0;
    timer_load  = 1'b0;
    timer_clear = 1'b0;
    timer_dec   = 1'b0;
    case (state_reg)
      IDLE: begin
        y_next = '0;
        if (accept) begin
          y_next     = decoded;
          timer_load = 1'b1;
          state_next = HOLD;
        end
      end
      HOLD: begin
        // Abort takes priority over a completion landing on the same cycle.
        if (!en) begin
          y_next      = '0;
          timer_clear = 1'b1;
          state_next  = IDLE;
        end else if (hold_end) begin
          y_next     = '0;
          done_next  = 1'b1;
          state_next = IDLE;
        end else begin
          timer_dec = 1'b1;
        end
      end
      default: begin
        y_next      = '0;
        timer_clear = 1'b1;
        state_next  = IDLE;
      end
    endcase
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      y_reg     <= '0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      y_reg     <= y_next;
      done_reg  <= done_next;
    end
  end

  assign y    = y_reg;
  assign done = done_reg;

endmodule : decoder_3to8_seq
